// File: rtl/fusion_pkg.sv
// Shared constants and encodings for the fusion front end: fetch queue and fusion decoder.
package fusion_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned PC_STEP   = 4;

   // Pair classification produced by the fusion decoder from a sequential slot0/slot1 window.
   typedef enum logic [1:0] {
      FUSE_NONE       = 2'b00,
      FUSE_LUI_ADDI   = 2'b01,
      FUSE_AUIPC_JALR = 2'b10,
      FUSE_LOAD_ALU   = 2'b11
   } fuse_type_e;

endpackage

// File: rtl/fusion_fetch_queue_if.sv
// Fetch-queue bus: fetch push side, decode retire side and the two-entry decode window.
interface fusion_fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  pc_in;
   logic [XLEN-1:0]  instr_in;
   logic [1:0]       consume;
   logic             flush;
   logic             slot0_valid;
   logic [XLEN-1:0]  slot0_pc;
   logic [XLEN-1:0]  slot0_instr;
   logic             slot1_valid;
   logic [XLEN-1:0]  slot1_pc;
   logic [XLEN-1:0]  slot1_instr;
   logic             slot1_seq;
   logic [CNT_W-1:0] count;

   // Master drives fetch and decode controls; slave is the queue itself.
   modport master (
      output in_valid, pc_in, instr_in, consume, flush,
      input  in_ready, slot0_valid, slot0_pc, slot0_instr,
             slot1_valid, slot1_pc, slot1_instr, slot1_seq, count
   );

   modport slave (
      input  in_valid, pc_in, instr_in, consume, flush,
      output in_ready, slot0_valid, slot0_pc, slot0_instr,
             slot1_valid, slot1_pc, slot1_instr, slot1_seq, count
   );

endinterface

// File: rtl/fusion_fetch_queue_mem.sv
// DEPTH-entry register array: one synchronous write port, two asynchronous read ports.
module fusion_fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr0,
   input  logic [PTR_W-1:0] raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fusion_fetch_queue.sv
// Fetch-to-fusion-decode instruction queue presenting the two oldest entries as a decode window.
module fusion_fetch_queue
   import fusion_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input logic                clk,
   input logic                rst,
   fusion_fetch_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic              enq;
   logic [CNT_W-1:0]  cons_req;
   logic [CNT_W-1:0]  eff;
   logic [2*XLEN-1:0] rdata0;
   logic [2*XLEN-1:0] rdata1;
   logic              v0;
   logic              v1;

   // Registered count only: a full queue holds off fetch for a cycle even while decode drains.
   assign bus.in_ready = (count_q != CNT_W'(DEPTH));
   assign enq          = bus.in_valid & bus.in_ready;

   // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
   always_comb begin
      cons_req = (bus.consume == 2'd3) ? CNT_W'(2) : CNT_W'(bus.consume);
      eff      = (cons_req > count_q) ? count_q : cons_req;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(enq);
         rd_ptr_q <= rd_ptr_q + PTR_W'(eff);
         count_q  <= count_q + CNT_W'(enq) - eff;
      end
   end

   fusion_fetch_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_mem (
      .clk    (clk),
      .we     (enq & ~bus.flush & ~rst),
      .waddr  (wr_ptr_q),
      .wdata  ({bus.pc_in, bus.instr_in}),
      .raddr0 (rd_ptr_q),
      .raddr1 (rd_ptr_q + PTR_W'(1)),
      .rdata0 (rdata0),
      .rdata1 (rdata1)
   );

   assign v0 = (count_q >= CNT_W'(1));
   assign v1 = (count_q >= CNT_W'(2));

   // Invalid slots show pc 0 and a NOP so decode can never act on stale storage.
   assign bus.slot0_valid = v0;
   assign bus.slot0_pc    = v0 ? rdata0[2*XLEN-1:XLEN] : '0;
   assign bus.slot0_instr = v0 ? rdata0[XLEN-1:0]      : XLEN'(NOP_INSTR);
   assign bus.slot1_valid = v1;
   assign bus.slot1_pc    = v1 ? rdata1[2*XLEN-1:XLEN] : '0;
   assign bus.slot1_instr = v1 ? rdata1[XLEN-1:0]      : XLEN'(NOP_INSTR);
   assign bus.slot1_seq   = v0 & v1 &
                            (rdata1[2*XLEN-1:XLEN] == rdata0[2*XLEN-1:XLEN] + XLEN'(PC_STEP));
   assign bus.count       = count_q;

endmodule
